arith_sequencer: RTL and testbench
==================================

// Module: arith_sequencer
// PURPOSE
//   Front end for arith_machine. Fetches 32-bit MIPS words over a req/ready instruction port.
//   Decodes the ALU subset and drives arith_machine's control bundle:
//   rs, rt, rd, rd_src, wr_enable, alu_src2, alu_op, imm16.
//   Replaces the hand-driven bench stimulus, so whole programs can run on the datapath.
// PARAMETERS
//   PC_RESET   32'h0040_0000  byte address of first fetch after reset/run
//   HALT_WORD  32'h0000_000D  instruction word (break) that stops the sequencer
// PORTS
//   clock       in   1   single clock; all state updates on posedge
//   reset       in   1   synchronous, active-low; reset==0 at posedge clears all state
//   run         in   1   level; IDLE->FETCH when 1
//   imem_req    out  1   fetch request; held high until accepted
//   imem_addr   out  32  byte address of requested word (== pc; bits[1:0]==0)
//   imem_ready  in   1   memory accepts req; imem_data valid in the same cycle
//   imem_data   in   32  instruction word
//   rs,rt,rd    out  5   register specifiers: instr[25:21], [20:16], [15:11]
//   rd_src      out  1   1 = write rt (I-type); 0 = write rd (R-type)
//   wr_enable   out  1   register-file write strobe; one cycle per valid instruction
//   alu_src2    out  2   00 = rt data; 01 = sign-ext imm16; 10 = zero-ext imm16
//   alu_op      out  3   arith_machine ALU op encoding
//   imm16       out  16  instr[15:0]
//   except      out  1   sticky; unrecognised instruction fetched
//   halted      out  1   sticky; HALT_WORD fetched or except raised
//   pc          out  32  current fetch address
// BEHAVIOUR
//   Reset values: pc=PC_RESET; state=IDLE; imem_req=0; wr_enable=0; except=0; halted=0.
//   Reset values, continued: rs/rt/rd/rd_src/alu_src2/alu_op/imm16 = 0.
//   FSM IDLE -> FETCH -> EXEC -> FETCH ...; any -> HALT; HALT is exited only by reset.
//   IDLE: imem_req=0; imem_ready is ignored; run=1 -> FETCH next cycle.
//   FETCH: imem_req=1, imem_addr=pc. While imem_ready=0 it stays in FETCH (wait states allowed).
//   FETCH, imem_ready=1 in cycle N: instruction is latched and decoded. All control outputs are registered.
//     - valid ALU instr: EXEC in N+1 with wr_enable=1 for exactly that cycle; pc+=4 at end of N+1.
//     - word==HALT_WORD: HALT in N+1; wr_enable=0; pc unchanged.
//     - unrecognised: HALT in N+1 with except=1, halted=1; wr_enable=0; pc unchanged.
//   EXEC: imem_req=0; next FETCH is in N+2. Throughput is one instruction per 2 cycles plus wait states.
//   Outside EXEC, wr_enable=0. Other control fields hold their last decoded value.
//   R-type (opcode 0) funct -> alu_op, alu_src2=00, rd_src=0:
//     add 0x20->010, sub 0x22->011, and 0x24->100, or 0x25->101, nor 0x27->110, xor 0x26->111.
//   I-type, rd_src=1:
//     addi 0x08 -> 010 with alu_src2=01.
//     andi 0x0C->100, ori 0x0D->101, xori 0x0E->111, each with alu_src2=10.
//   Any other opcode or funct is unrecognised. shamt!=0 on R-type is unrecognised.
//   Writes to $0 are still issued with wr_enable=1; the register file ignores them.
//   pc wraps modulo 2^32 with no flag.
//   run dropping mid-program has no effect; run is sampled only in IDLE.
//   reset=0 mid-FETCH drops imem_req in the following cycle. Any partial fetch is discarded.
//   reset=0 during EXEC: the write strobe still occurs in that cycle (already registered).
//     wr_enable=0 from the next cycle.
// STRUCTURE
//   Package arith_defs: ALU_ADD..ALU_XOR 3-bit constants, OPC_*/FUNCT_* 6-bit constants.
//   Package arith_defs also holds SRC2_REG/SRC2_SEXT/SRC2_ZEXT and the state enum IDLE/FETCH/EXEC/HALT.
//   Sub-module arith_decoder: purely combinational.
//     Inputs: instr[31:0]. Outputs: control bundle, valid, is_halt.
//     The sequencer registers its outputs on imem_ready.
//   Top level holds the FSM, the pc register and the output registers.
//   Integration: instantiate arith_sequencer -> arith_machine, sharing clock.
//     Drive arith_machine.reset with ~reset.
// TESTING
//   1 reset=0 2 cycles, then reset=1, run=0 -> imem_req=0, pc=0x00400000, all ctl outputs 0 for 10 cycles.
//   2 run=1, imem_data=0x20010AAA (addi $1,$0,0xaaa), ready=1 ->
//     next cycle wr_enable=1, rs=0, rt=1, rd_src=1, alu_src2=01, alu_op=010, imm16=0x0AAA.
//     Then pc=0x00400004.
//   3 ori $5,$1,5 (0x34250005) then add $6,$2,$3 (0x00433020) ->
//     first: alu_op=101, alu_src2=10, rt=5.
//     second: rd=6, rd_src=0, alu_src2=00, alu_op=010.
//     Each has a single wr_enable pulse, 2 cycles apart.
//   4 Hold imem_ready=0 for 3 cycles in FETCH -> imem_req stays 1, imem_addr stable, wr_enable=0.
//     Pulse issues 1 cycle after ready.
//   5 Fetch 0x0000000D -> halted=1, except=0, pc unchanged.
//     Fetch 0xFC000000 (bad opcode) -> except=1, halted=1, no wr_enable.
//     Both stay set until reset.
//   6 reset=0 asserted during FETCH wait -> imem_req=0 next cycle, pc=PC_RESET, state IDLE.
//     End-to-end: run program on arith_machine, compare regfile to golden dump.

Source files
------------

// File: rtl/arith_defs.sv
// Shared constants and types for the arith_machine front end: ALU op codes,
// MIPS opcode/funct values, operand-2 select codes, sequencer states, control bundle.
package arith_defs;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_NOR = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b111;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  localparam logic [1:0] SRC2_REG  = 2'b00;
  localparam logic [1:0] SRC2_SEXT = 2'b01;
  localparam logic [1:0] SRC2_ZEXT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic        rd_src;
    logic [1:0]  alu_src2;
    logic [2:0]  alu_op;
    logic [15:0] imm16;
  } ctl_t;

endpackage

// File: rtl/arith_decoder.sv
// Combinational decoder for the supported MIPS ALU subset; flags the halt word
// separately so the sequencer can stop without raising an exception.
module arith_decoder
  import arith_defs::*;
#(
  parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
  input  logic [31:0] instr_i,
  output ctl_t        ctl_o,
  output logic        valid_o,
  output logic        is_halt_o
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] shamt;

  assign opcode    = instr_i[31:26];
  assign funct     = instr_i[5:0];
  assign shamt     = instr_i[10:6];
  assign is_halt_o = (instr_i == HALT_WORD);

  always_comb begin
    ctl_o.rs       = instr_i[25:21];
    ctl_o.rt       = instr_i[20:16];
    ctl_o.rd       = instr_i[15:11];
    ctl_o.imm16    = instr_i[15:0];
    ctl_o.rd_src   = 1'b1;
    ctl_o.alu_src2 = SRC2_ZEXT;
    ctl_o.alu_op   = ALU_ADD;
    valid_o        = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        ctl_o.rd_src   = 1'b0;
        ctl_o.alu_src2 = SRC2_REG;
        case (funct)
          FUNCT_ADD: ctl_o.alu_op = ALU_ADD;
          FUNCT_SUB: ctl_o.alu_op = ALU_SUB;
          FUNCT_AND: ctl_o.alu_op = ALU_AND;
          FUNCT_OR:  ctl_o.alu_op = ALU_OR;
          FUNCT_NOR: ctl_o.alu_op = ALU_NOR;
          FUNCT_XOR: ctl_o.alu_op = ALU_XOR;
          default:   valid_o = 1'b0;
        endcase
        // Shift amounts are meaningless for these ops, so a non-zero field is malformed.
        if (shamt != 5'd0) valid_o = 1'b0;
      end
      OPC_ADDI: begin
        ctl_o.alu_op   = ALU_ADD;
        ctl_o.alu_src2 = SRC2_SEXT;
      end
      OPC_ANDI: ctl_o.alu_op = ALU_AND;
      OPC_ORI:  ctl_o.alu_op = ALU_OR;
      OPC_XORI: ctl_o.alu_op = ALU_XOR;
      default:  valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/arith_sequencer.sv
// Instruction fetch/decode sequencer driving arith_machine's control bundle:
// IDLE -> FETCH -> EXEC -> FETCH ..., with HALT left only through reset.
module arith_sequencer
  import arith_defs::*;
#(
  parameter logic [31:0] PC_RESET  = 32'h0040_0000,
  parameter logic [31:0] HALT_WORD = 32'h0000_000D
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic        rd_src,
  output logic        wr_enable,
  output logic [1:0]  alu_src2,
  output logic [2:0]  alu_op,
  output logic [15:0] imm16,
  output logic        except,
  output logic        halted,
  output logic [31:0] pc
);

  state_t state_q, state_d;
  logic [31:0] pc_q;
  ctl_t        ctl_q;
  logic        except_q;

  ctl_t dec_ctl;
  logic dec_valid;
  logic dec_halt;
  logic accept;

  arith_decoder #(.HALT_WORD(HALT_WORD)) u_decoder (
    .instr_i   (imem_data),
    .ctl_o     (dec_ctl),
    .valid_o   (dec_valid),
    .is_halt_o (dec_halt)
  );

  assign accept = (state_q == FETCH) && imem_ready;

  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (run) state_d = FETCH;
      FETCH:   if (accept) state_d = (dec_valid && !dec_halt) ? EXEC : HALT;
      EXEC:    state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == FETCH);
    wr_enable = (state_q == EXEC);
    halted    = (state_q == HALT);
  end

  // Control fields only change on a good instruction; halt and bad words leave them as-is.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q     <= PC_RESET;
      ctl_q    <= '0;
      except_q <= 1'b0;
    end else begin
      if (state_q == EXEC) pc_q <= pc_q + 32'd4;
      if (accept && dec_valid && !dec_halt) ctl_q <= dec_ctl;
      if (accept && !dec_valid && !dec_halt) except_q <= 1'b1;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign rs        = ctl_q.rs;
  assign rt        = ctl_q.rt;
  assign rd        = ctl_q.rd;
  assign rd_src    = ctl_q.rd_src;
  assign alu_src2  = ctl_q.alu_src2;
  assign alu_op    = ctl_q.alu_op;
  assign imm16     = ctl_q.imm16;
  assign except    = except_q;

endmodule

// File: tb/tb_arith_sequencer.sv
// Scoreboard bench for arith_sequencer: a memory driver feeds random programs and
// pushes expected control bundles; a monitor pops and compares on each write strobe.
module tb_arith_sequencer;

  localparam logic [31:0] PC_RST = 32'h0040_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_data = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [4:0]  rs, rt, rd;
  logic        rd_src, wr_enable, except, halted;
  logic [1:0]  alu_src2;
  logic [2:0]  alu_op;
  logic [15:0] imm16;
  logic [31:0] pc;

  arith_sequencer dut (
    .clock(clock), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_data(imem_data),
    .rs(rs), .rt(rt), .rd(rd), .rd_src(rd_src), .wr_enable(wr_enable),
    .alu_src2(alu_src2), .alu_op(alu_op), .imm16(imm16),
    .except(except), .halted(halted), .pc(pc)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        rd_src;
    logic [1:0]  src2;
    logic [2:0]  alu;
    logic [15:0] imm;
    logic [31:0] pc;
    int          cyc;
    logic [31:0] word;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] prog[$];
  logic [31:0] model_pc = PC_RST;
  int          cyc = 0;
  bit          mem_en = 0;
  bit          term_seen = 0;
  int          term_kind = 0;
  int          force_wait = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_assert++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference decode straight from the instruction table: 0 = ALU op, 1 = halt, 2 = illegal.
  function automatic int ref_decode(input logic [31:0] w, output exp_t e);
    logic [5:0] op;
    logic [5:0] fn;
    op = w[31:26];
    fn = w[5:0];
    e.rs = w[25:21]; e.rt = w[20:16]; e.rd = w[15:11]; e.imm = w[15:0];
    e.rd_src = 1'b0; e.src2 = 2'd0; e.alu = 3'd0; e.pc = 32'd0; e.cyc = 0; e.word = w;
    if (w == 32'h0000_000D) return 1;
    if (op == 6'h00) begin
      if (w[10:6] != 5'd0) return 2;
      case (fn)
        6'h20: e.alu = 3'b010;
        6'h22: e.alu = 3'b011;
        6'h24: e.alu = 3'b100;
        6'h25: e.alu = 3'b101;
        6'h27: e.alu = 3'b110;
        6'h26: e.alu = 3'b111;
        default: return 2;
      endcase
      return 0;
    end
    e.rd_src = 1'b1;
    case (op)
      6'h08: begin e.alu = 3'b010; e.src2 = 2'b01; end
      6'h0C: begin e.alu = 3'b100; e.src2 = 2'b10; end
      6'h0D: begin e.alu = 3'b101; e.src2 = 2'b10; end
      6'h0E: begin e.alu = 3'b111; e.src2 = 2'b10; end
      default: return 2;
    endcase
    return 0;
  endfunction

  function automatic logic [31:0] rand_valid();
    int k;
    logic [5:0] code;
    k = $urandom_range(0, 9);
    case (k)
      0: code = 6'h20;
      1: code = 6'h22;
      2: code = 6'h24;
      3: code = 6'h25;
      4: code = 6'h27;
      5: code = 6'h26;
      6: code = 6'h08;
      7: code = 6'h0C;
      8: code = 6'h0D;
      default: code = 6'h0E;
    endcase
    if (k < 6) return {6'd0, 5'($urandom), 5'($urandom), 5'($urandom), 5'd0, code};
    return {code, 5'($urandom), 5'($urandom), 16'($urandom)};
  endfunction

  function automatic logic [31:0] rand_bad();
    case ($urandom_range(0, 2))
      0: return {6'h3F, 26'($urandom)};
      1: return {6'd0, 15'($urandom), 5'($urandom_range(1, 31)), 6'h20};
      default: return {6'd0, 15'($urandom), 5'd0, 6'h01};
    endcase
  endfunction

  // Memory driver: answers requests with random wait states and records expectations.
  initial begin
    logic [31:0] w;
    exp_t e;
    int k;
    forever begin
      @(negedge clock);
      imem_ready = 1'b0;
      imem_data  = $urandom;
      if (imem_req === 1'b1) begin
        check("fetch_addr", imem_addr, model_pc);
        if (force_wait > 0) begin
          force_wait--;
        end else if (mem_en && prog.size() > 0 && $urandom_range(0, 2) != 0) begin
          w = prog.pop_front();
          imem_ready = 1'b1;
          imem_data  = w;
          k = ref_decode(w, e);
          if (k == 0) begin
            e.pc  = model_pc;
            e.cyc = cyc + 1;
            expq.push_back(e);
            model_pc = model_pc + 32'd4;
          end else begin
            term_kind = k;
            term_seen = 1;
          end
        end
      end
    end
  end

  // Monitor: every write strobe must match the oldest outstanding expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (wr_enable === 1'b1) begin
        if (expq.size() == 0) begin
          n_assert++;
          n_fail++;
          $display("FAIL unexpected_wr: got wr_enable=1 at pc=%h, expected no pending write", pc);
        end else begin
          e = expq.pop_front();
          $display("wr  word=%h pc=%h rs=%0d rt=%0d rd=%0d rd_src=%0d src2=%0d op=%0d imm=%h",
                   e.word, pc, rs, rt, rd, rd_src, alu_src2, alu_op, imm16);
          check("wr_rs", rs, e.rs);
          check("wr_rt", rt, e.rt);
          check("wr_rd", rd, e.rd);
          check("wr_rd_src", rd_src, e.rd_src);
          check("wr_alu_src2", alu_src2, e.src2);
          check("wr_alu_op", alu_op, e.alu);
          check("wr_imm16", imm16, e.imm);
          check("wr_pc", pc, e.pc);
          check("wr_latency", cyc, e.cyc);
          check("wr_req_low", imem_req, 1'b0);
          check("wr_halted_low", halted, 1'b0);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    run = 1'b0;
    mem_en = 0;
    repeat (2) @(negedge clock);
    expq.delete();
    prog.delete();
    model_pc = PC_RST;
    term_seen = 0;
    term_kind = 0;
    force_wait = 0;
    reset = 1'b1;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_wr"}, wr_enable, 1'b0);
    check({tag, "_pc"}, pc, PC_RST);
    check({tag, "_ctl"}, {rs, rt, rd, rd_src, alu_src2, alu_op, imm16}, 32'd0);
    check({tag, "_except"}, except, 1'b0);
    check({tag, "_halted"}, halted, 1'b0);
  endtask

  task automatic wait_done(input string tag);
    int t;
    t = 0;
    while (!(term_seen && expq.size() == 0) && t < 2000) begin
      @(negedge clock);
      t++;
    end
    n_assert++;
    if (t >= 2000) begin
      n_fail++;
      $display("FAIL %s_timeout: got no halt after %0d cycles, expected halt", tag, t);
    end
    repeat (3) @(negedge clock);
    check({tag, "_halted"}, halted, 1'b1);
    check({tag, "_except"}, except, (term_kind == 2) ? 1'b1 : 1'b0);
    check({tag, "_pc"}, pc, model_pc);
    check({tag, "_req"}, imem_req, 1'b0);
    repeat (5) @(negedge clock);
    check({tag, "_halted_sticky"}, halted, 1'b1);
    check({tag, "_except_sticky"}, except, (term_kind == 2) ? 1'b1 : 1'b0);
    $display("prog %s done: pc=%h halted=%0d except=%0d", tag, pc, halted, except);
  endtask

  initial begin
    int t;
    int n;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      check_cleared("idle");
    end

    // Directed program: addi, ori, add, then halt.
    prog = '{32'h20010AAA, 32'h34250005, 32'h00433020, 32'h0000000D};
    mem_en = 1;
    run = 1'b1;
    wait_done("directed");
    check("directed_final_pc", pc, PC_RST + 32'd12);

    // Wait states: three cycles of ready=0 before the first word.
    do_reset();
    prog = '{32'h3C000000 | 32'h00000000, 32'h0000000D};
    prog[0] = 32'h31E7FFFF;
    force_wait = 3;
    mem_en = 1;
    run = 1'b1;
    wait_done("waitstate");

    // Illegal opcode after one good instruction.
    do_reset();
    prog = '{32'h00853822, 32'hFC000000};
    mem_en = 1;
    run = 1'b1;
    wait_done("badop");

    // Reset while stalled in FETCH at a non-reset address.
    do_reset();
    prog = '{32'h00221825, 32'h38A5F0F0};
    mem_en = 1;
    run = 1'b1;
    t = 0;
    while (!(prog.size() == 0 && expq.size() == 0) && t < 500) begin
      @(negedge clock);
      t++;
    end
    repeat (2) @(negedge clock);
    check("stall_req", imem_req, 1'b1);
    check("stall_addr", imem_addr, PC_RST + 32'd8);
    reset = 1'b0;
    @(negedge clock);
    check("midreset_req", imem_req, 1'b0);
    check("midreset_pc", pc, PC_RST);
    check("midreset_wr", wr_enable, 1'b0);
    model_pc = PC_RST;
    expq.delete();
    @(negedge clock);
    reset = 1'b1;
    prog = '{rand_valid(), rand_valid(), 32'h0000000D};
    wait_done("after_reset");

    // Random programs; run is sometimes dropped mid-program and must be ignored.
    for (int p = 0; p < 20; p++) begin
      do_reset();
      n = $urandom_range(1, 12);
      for (int i = 0; i < n; i++) prog.push_back(rand_valid());
      prog.push_back(($urandom_range(0, 1) == 1) ? rand_bad() : 32'h0000000D);
      mem_en = 1;
      run = 1'b1;
      repeat (3) @(negedge clock);
      run = 1'($urandom_range(0, 1));
      wait_done($sformatf("rand%0d", p));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
